// File: rtl/msb_drain_scheduler.sv
// Drains a pending-request vector most-significant-bit first, locating each
// winner with a one-stage-per-cycle binary search over a power-of-two padded copy.
module msb_drain_scheduler #(
  parameter int WIDTH     = 56,
  parameter int WIDTH_LOG = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     req_vec,
  input  logic                 abort,
  output logic                 busy,
  output logic                 gnt_valid,
  input  logic                 gnt_ready,
  output logic [WIDTH_LOG-1:0] gnt_idx,
  output logic                 gnt_last,
  output logic                 done,
  output logic [WIDTH_LOG:0]   gnt_count
);

  localparam int PAD    = 1 << WIDTH_LOG;
  localparam int STEP_W = (WIDTH_LOG > 1) ? $clog2(WIDTH_LOG) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WIDTH_LOG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SEARCH,
    S_GRANT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       pending_q, pending_d;
  logic [WIDTH_LOG-1:0]   lo_q, lo_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic [WIDTH_LOG:0]     count_q, count_d;

  logic [PAD-1:0]         pend_pad;
  logic [PAD-1:0]         pend_clr;
  logic [PAD-1:0]         win_mask;
  logic [PAD-1:0]         window;
  logic [WIDTH_LOG-1:0]   half;
  logic [WIDTH_LOG:0]     win_base;
  logic                   upper_hit;

  // One shared OR-reduce: the upper half of the current window [lo, lo+2*half)
  always_comb begin
    pend_pad              = '0;
    pend_pad[WIDTH-1:0]   = pending_q;
    half                  = WIDTH_LOG'(1) << (STEP_LAST - step_q);
    win_base              = {1'b0, lo_q} + {1'b0, half};
    win_mask              = ~({PAD{1'b1}} << half);
    window                = (pend_pad >> win_base) & win_mask;
    upper_hit             = |window;
    pend_clr              = pend_pad & ~({{(PAD-1){1'b0}}, 1'b1} << lo_q);
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    lo_d      = lo_q;
    step_d    = step_q;
    count_d   = count_q;

    if (state_q != S_IDLE && abort) begin
      // Abort wins over any simultaneous handshake; the count is kept
      state_d   = S_IDLE;
      pending_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pending_d = req_vec;
            count_d   = '0;
            state_d   = S_CHECK;
          end
        end
        S_CHECK: begin
          if (pending_q == '0) begin
            state_d = S_DONE;
          end else begin
            lo_d    = '0;
            step_d  = '0;
            state_d = S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (upper_hit) begin
            lo_d = win_base[WIDTH_LOG-1:0];
          end
          if (step_q == STEP_LAST) begin
            state_d = S_GRANT;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
        S_GRANT: begin
          if (gnt_ready) begin
            pending_d = pend_clr[WIDTH-1:0];
            count_d   = count_q + (WIDTH_LOG+1)'(1);
            state_d   = S_CHECK;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      lo_q      <= '0;
      step_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      lo_q      <= lo_d;
      step_q    <= step_d;
      count_q   <= count_d;
    end
  end

  // Grant outputs decode registered state only, so gnt_ready never reaches them
  assign busy      = (state_q != S_IDLE);
  assign gnt_valid = (state_q == S_GRANT);
  assign gnt_idx   = gnt_valid ? lo_q : '0;
  assign gnt_last  = gnt_valid && (pend_clr == '0);
  assign done      = (state_q == S_DONE);
  assign gnt_count = count_q;

endmodule

// File: tb/tb_msb_drain_scheduler.sv
// Scoreboard bench for msb_drain_scheduler: stimulus pushes expected grants,
// a negedge monitor pops and compares each accepted grant.
module tb_msb_drain_scheduler;

  localparam int WIDTH = 56;
  localparam int WL    = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] req_vec;
  logic             abort;
  logic             busy;
  logic             gnt_valid;
  logic             gnt_ready;
  logic [WL-1:0]    gnt_idx;
  logic             gnt_last;
  logic             done;
  logic [WL:0]      gnt_count;

  msb_drain_scheduler #(.WIDTH(WIDTH), .WIDTH_LOG(WL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .req_vec   (req_vec),
    .abort     (abort),
    .busy      (busy),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready),
    .gnt_idx   (gnt_idx),
    .gnt_last  (gnt_last),
    .done      (done),
    .gnt_count (gnt_count)
  );

  always #5 clk = ~clk;

  int testsRun       = 0;
  int testsFailed    = 0;
  int expIdx[$];
  bit expLast[$];
  int cycleCount     = 0;
  int lastGrantCycle = -1;
  bit spacingCheck   = 1'b0;
  int doneCount      = 0;
  int monIdx;
  bit monLast;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every accepted grant is compared against the head of the scoreboard
  always @(negedge clk) begin
    if (done) doneCount++;
    if (rst_n && gnt_valid && gnt_ready && !abort) begin
      if (expIdx.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedGrant: got idx %0d, expected no grant", gnt_idx);
      end else begin
        monIdx  = expIdx.pop_front();
        monLast = expLast.pop_front();
        checkOutput("grantIdx", 64'(gnt_idx), 64'(monIdx));
        checkOutput("grantLast", 64'(gnt_last), 64'(monLast));
        if (spacingCheck && lastGrantCycle >= 0)
          checkOutput("grantSpacing", 64'(cycleCount - lastGrantCycle), 64'd8);
        lastGrantCycle = cycleCount;
      end
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] vec, input bit pushExp);
    int lowest;
    @(posedge clk);
    #1;
    lastGrantCycle = -1;
    if (pushExp) begin
      lowest = -1;
      for (int i = 0; i < WIDTH; i++)
        if (vec[i] && lowest < 0) lowest = i;
      for (int i = WIDTH - 1; i >= 0; i--)
        if (vec[i]) begin
          expIdx.push_back(i);
          expLast.push_back(i == lowest);
        end
    end
    start   = 1'b1;
    req_vec = vec;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitValid(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (gnt_valid) found = 1'b1;
    end
    checkOutput(name, 64'(found), 64'd1);
  endtask

  task automatic waitDone(input string name, input int bound);
    bit found;
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    checkOutput(name, 64'(found), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int d0;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    gnt_ready = 1'b0;
    req_vec   = '0;
    #12;
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstValid", 64'(gnt_valid), 64'd0);
    checkOutput("rstIdx", 64'(gnt_idx), 64'd0);
    checkOutput("rstLast", 64'(gnt_last), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);
    checkOutput("rstCount", 64'(gnt_count), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single top bit: first grant after 8 edges, idx 55 last
    gnt_ready = 1'b1;
    d0 = doneCount;
    applyStimulus(56'h80000000000000, 1'b1);
    n = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gnt_valid) break;
      @(posedge clk);
      n++;
    end
    checkOutput("t1Latency", 64'(n), 64'd8);
    checkOutput("t1Idx", 64'(gnt_idx), 64'd55);
    waitDone("t1Done", 50);
    @(posedge clk);
    #1;
    checkOutput("t1Count", 64'(gnt_count), 64'd1);
    checkOutput("t1DonePulses", 64'(doneCount - d0), 64'd1);
    checkOutput("t1Queue", 64'(expIdx.size()), 64'd0);

    // All ones: 56 descending grants, 8 edges apart
    spacingCheck = 1'b1;
    d0 = doneCount;
    applyStimulus({WIDTH{1'b1}}, 1'b1);
    waitDone("t2Done", 1000);
    @(posedge clk);
    #1;
    spacingCheck = 1'b0;
    checkOutput("t2Count", 64'(gnt_count), 64'd56);
    checkOutput("t2DonePulses", 64'(doneCount - d0), 64'd1);
    checkOutput("t2Queue", 64'(expIdx.size()), 64'd0);

    // Empty vector: done two edges after start, idle on the third
    d0 = doneCount;
    applyStimulus('0, 1'b1);
    @(negedge clk);
    checkOutput("t3DoneEarly", 64'(done), 64'd0);
    @(negedge clk);
    checkOutput("t3DonePulse", 64'(done), 64'd1);
    checkOutput("t3NoValid", 64'(gnt_valid), 64'd0);
    @(negedge clk);
    checkOutput("t3DoneAfter", 64'(done), 64'd0);
    checkOutput("t3BusyLow", 64'(busy), 64'd0);
    checkOutput("t3Count", 64'(gnt_count), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("t3DonePulses", 64'(doneCount - d0), 64'd1);

    // Stalled consumer: grant held stable
    gnt_ready = 1'b0;
    applyStimulus(56'h5, 1'b1);
    waitValid("t4Valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t4HoldValid", 64'(gnt_valid), 64'd1);
      checkOutput("t4HoldIdx", 64'(gnt_idx), 64'd2);
      checkOutput("t4HoldLast", 64'(gnt_last), 64'd0);
    end
    @(posedge clk);
    #1;
    gnt_ready = 1'b1;
    waitDone("t4Done", 100);
    @(posedge clk);
    #1;
    checkOutput("t4Count", 64'(gnt_count), 64'd2);
    checkOutput("t4Queue", 64'(expIdx.size()), 64'd0);

    // Abort together with a handshake: not counted, no done
    gnt_ready = 1'b0;
    d0 = doneCount;
    applyStimulus(56'h3, 1'b0);
    waitValid("t5Valid");
    @(posedge clk);
    #1;
    abort     = 1'b1;
    gnt_ready = 1'b1;
    @(posedge clk);
    #1;
    abort     = 1'b0;
    checkOutput("t5Busy", 64'(busy), 64'd0);
    checkOutput("t5Valid0", 64'(gnt_valid), 64'd0);
    checkOutput("t5Count", 64'(gnt_count), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t5NoDone", 64'(doneCount - d0), 64'd0);
    applyStimulus(56'h1, 1'b1);
    waitDone("t5Done2", 100);
    @(posedge clk);
    #1;
    checkOutput("t5Count2", 64'(gnt_count), 64'd1);
    checkOutput("t5Queue", 64'(expIdx.size()), 64'd0);

    // Asynchronous reset in the middle of the second search
    applyStimulus(56'h3, 1'b1);
    waitValid("t6Valid");
    repeat (3) @(posedge clk);
    #3;
    checkOutput("t6PreBusy", 64'(busy), 64'd1);
    checkOutput("t6PreCount", 64'(gnt_count), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6Busy", 64'(busy), 64'd0);
    checkOutput("t6Valid", 64'(gnt_valid), 64'd0);
    checkOutput("t6Idx", 64'(gnt_idx), 64'd0);
    checkOutput("t6Last", 64'(gnt_last), 64'd0);
    checkOutput("t6Done", 64'(done), 64'd0);
    checkOutput("t6Count", 64'(gnt_count), 64'd0);
    expIdx.delete();
    expLast.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // start while busy is ignored
    d0 = doneCount;
    applyStimulus(56'h5, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start   = 1'b1;
    req_vec = 56'hF0;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("t7Done", 100);
    @(posedge clk);
    #1;
    checkOutput("t7Count", 64'(gnt_count), 64'd2);
    checkOutput("t7DonePulses", 64'(doneCount - d0), 64'd1);
    checkOutput("t7Queue", 64'(expIdx.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/msb_drain_scheduler.md
Name: msb_drain_scheduler

Overview:
- Sequential scheduler that drains a WIDTH-bit pending-request vector in strict most-significant-first order.
- The MSB search runs as a binary search over padded power-of-two halves, one halving stage per clock. Each stage is time-multiplexed through a single OR-reduce stage instead of an unrolled encoder chain.
- Each winner is issued as an index over a valid/ready grant handshake, its bit is cleared, and the search repeats until the vector is empty.
- Sits between request-collection logic and a consumer of serviced indices.

Parameters:
WIDTH, 56, number of request bits.
WIDTH_LOG, 6, index width. Must satisfy 2**WIDTH_LOG >= WIDTH. The vector is zero-extended to 2**WIDTH_LOG bits internally.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  load req_vec and begin draining; honoured only in IDLE
req_vec  input  WIDTH  request mask sampled on accepted start
abort  input  1  synchronous cancel of the current drain
busy  output  1  high in every state except IDLE
gnt_valid  output  1  grant index valid
gnt_ready  input  1  consumer accepts grant
gnt_idx  output  WIDTH_LOG  index of current highest pending bit
gnt_last  output  1  current grant is the final set bit
done  output  1  one-cycle pulse: vector fully drained
gnt_count  output  WIDTH_LOG+1  grants accepted since last start

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; pending=0; lo=0; step=0; busy=0; gnt_valid=0; gnt_idx=0; gnt_last=0; done=0; gnt_count=0.
- Reset asserted mid-operation drops everything to reset values immediately. No done pulse is produced.
- IDLE:
  - start=1 → pending<=req_vec, gnt_count<=0, go to CHECK.
  - start is ignored in all other states.
- CHECK:
  - pending==0 → DONE.
  - Otherwise lo<=0, step<=0, go to SEARCH.
- SEARCH, one stage per cycle, step = 0..WIDTH_LOG-1:
  - half = 2**(WIDTH_LOG-1-step).
  - If |pending_padded[lo+half +: half] then lo<=lo+half; otherwise lo is unchanged.
  - After step WIDTH_LOG-1, go to GRANT.
  - The search always takes exactly WIDTH_LOG cycles, independent of data.
- GRANT:
  - gnt_valid=1, gnt_idx=lo.
  - gnt_last=1 iff pending with bit lo cleared is zero.
  - Outputs are held stable while gnt_ready=0, with no timeout.
  - On gnt_valid & gnt_ready: pending[lo]<=0, gnt_count<=gnt_count+1, go to CHECK.
- DONE: done=1 for exactly one cycle, then IDLE. gnt_count holds its value until the next accepted start.
- Latency, with start sampled at edge E0:
  - Non-empty vector: gnt_valid is first high after edge E(WIDTH_LOG+1), i.e. 8 edges for the defaults.
  - Handshake to next gnt_valid: WIDTH_LOG+2 edges.
  - Empty vector: done is high in the cycle after E1.
- Outputs are registered. gnt_idx, gnt_valid and gnt_last are decoded from state/lo, with no combinational path from gnt_ready.
- abort=1 in any non-IDLE state → IDLE next edge.
  - Clears pending; no done pulse; gnt_count is held.
  - abort takes priority over a simultaneous handshake: that grant is not counted and pending is not modified.
  - abort in IDLE has no effect.
  - start and abort together in IDLE → start is accepted.
- Bits of the padded vector at or above WIDTH are always 0, so gnt_idx is never >= WIDTH.
- gnt_count is at most WIDTH, so WIDTH_LOG+1 bits never overflow.

Test Plan:
- req_vec=1<<55, gnt_ready=1 → gnt_valid after 8 edges with gnt_idx=55, gnt_last=1; done next; gnt_count=1.
- req_vec all 56 ones, gnt_ready=1 →
  - 56 grants, idx 55,54,…,0 descending, each spaced 8 edges.
  - gnt_last only on idx 0; done once; gnt_count=56.
- req_vec=0 → no gnt_valid; done pulses 2 edges after start; gnt_count=0; busy low after 3 edges.
- req_vec=0x5 with gnt_ready low for 5 cycles at the first grant → gnt_idx=2 and gnt_valid held stable throughout; then idx 0 with gnt_last=1; gnt_count=2.
- abort asserted together with gnt_ready during the GRANT of req_vec=0x3 → no count increment; IDLE next edge; no done. A later start with req_vec=0x1 → idx 0, gnt_count=1.
- Two further cases:
  - rst_n pulsed low mid-SEARCH → all outputs zero immediately, asynchronously.
  - start asserted while busy → ignored; the drain completes with the original mask.
